// File: rtl/jtgng_romarb.sv
// jtgng_romarb: round-robin SDRAM read arbiter with per-channel one-entry tag cache; define JTGNG_ROMARB_PRIO_EN to give channel 0 fixed priority
module jtgng_romarb #(
  parameter int CH = 4,
  parameter int AW = 22,
  parameter logic [CH*AW-1:0] OFFSET = '0
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic [CH-1:0]   ch_cs,
  input  logic [CH*AW-1:0] ch_addr,
  output logic [CH*16-1:0] ch_dout,
  output logic [CH-1:0]   ch_ok,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            sdram_rdy,
  input  logic [15:0]     data_read,
  output logic            autorefresh
);
`ifdef JTGNG_ROMARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam int LW = $clog2(CH);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
  state_t state, state_nxt;
  logic [LW-1:0] last, win;
  logic found, grant, discard;
  logic [CH-1:0] valid, pending;
  logic [CH*AW-1:0] tag;
  logic [AW-1:0] rel_addr;
  assign pending = ch_cs & ~ch_ok;
  assign grant = state == IDLE && state_nxt == WAIT_ACK;
  // a channel hits when its current address matches the address last fetched for it
  always_comb begin
    ch_ok = '0;
    for (int n = 0; n < CH; n++)
      ch_ok[n] = ch_cs[n] & valid[n] & (tag[n*AW +: AW] == ch_addr[n*AW +: AW]);
  end
  // winner search starts just after the last granted channel; channel 0 may preempt
  always_comb begin
    int k;
    k = 0;
    found = PRIO && pending[0];
    win = found ? '0 : last;
    for (int i = 1; i <= CH; i++) begin
      k = (int'(last) + i) % CH;
      if (!found && pending[k] && !(PRIO && k == 0)) begin
        win = LW'(k);
        found = 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: one request outstanding at a time
  always_comb
    state_nxt = state == IDLE     ? (!downloading && |pending ? WAIT_ACK : IDLE) :
                state == WAIT_ACK ? (sdram_ack ? WAIT_DATA : WAIT_ACK) :
                                    (sdram_rdy ? IDLE : WAIT_DATA);
  // state-decoded outputs; autorefresh is also forced high while reset is held
  always_comb begin
    sdram_req = state == WAIT_ACK;
    autorefresh = !rst_n || (state == IDLE && (!(|pending) || downloading));
  end
  // grant capture, data/tag store, and discard of transactions overlapped by a download
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last <= LW'(CH - 1);
      sdram_addr <= '0;
      rel_addr <= '0;
      ch_dout <= '0;
      tag <= '0;
      valid <= '0;
      discard <= 1'b0;
    end else begin
      if (grant) begin
        last <= win;
        rel_addr <= ch_addr[win*AW +: AW];
        sdram_addr <= ch_addr[win*AW +: AW] + OFFSET[win*AW +: AW];
      end
      discard <= state == IDLE ? 1'b0 : discard | downloading;
      if (downloading) valid <= '0;
      else if (state == WAIT_DATA && sdram_rdy && !discard) begin
        ch_dout[last*16 +: 16] <= data_read;
        tag[last*AW +: AW] <= rel_addr;
        valid[last] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_jtgng_romarb.sv
// tb_jtgng_romarb: directed plus randomized checks of the ROM arbiter against a cache/round-robin model
module tb_jtgng_romarb;
  localparam int CH = 4;
  localparam int AW = 22;
  localparam logic [CH*AW-1:0] OFFSET = {22'h3FFF00, 22'h200000, 22'h010000, 22'h00C000};
  logic clk = 0, rst_n = 0, downloading = 0, sdram_ack = 0, sdram_rdy = 0;
  logic [CH-1:0] ch_cs = '0;
  logic [CH*AW-1:0] ch_addr = '0;
  logic [15:0] data_read = '0;
  logic [CH*16-1:0] ch_dout;
  logic [CH-1:0] ch_ok;
  logic sdram_req, autorefresh;
  logic [AW-1:0] sdram_addr;
  int vectors = 0, errors = 0;
  bit mval [CH];
  logic [AW-1:0] mtag [CH];
  logic [15:0] mdata [CH];
  int mlast = CH - 1, mwin = 0;
  logic [AW-1:0] mrel, mabs;
  bit mdisc = 0;
  logic [AW-1:0] pool [4] = '{22'h000010, 22'h000011, 22'h000200, 22'h3FFFF0};

  jtgng_romarb #(.CH(CH), .AW(AW), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .ch_cs(ch_cs), .ch_addr(ch_addr),
    .ch_dout(ch_dout), .ch_ok(ch_ok), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .data_read(data_read), .autorefresh(autorefresh)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] off(input int n);
    return OFFSET[n*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] adr(input int n);
    return ch_addr[n*AW +: AW];
  endfunction

  function automatic bit mok(input int n);
    return ch_cs[n] && mval[n] && mtag[n] == adr(n);
  endfunction

  // round-robin rule: first requesting, non-hitting channel after the last grant
  function automatic int mpick();
    for (int i = 1; i <= CH; i++)
      if (ch_cs[(mlast + i) % CH] && !mok((mlast + i) % CH)) return (mlast + i) % CH;
    return -1;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < CH; n++) mval[n] = 0;
    mlast = CH - 1;
    mdisc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_req(input int w);
    int t;
    t = 0;
    while (!sdram_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", 64'(sdram_req), 64'd1);
    mabs = AW'(adr(w) + off(w));
    chk($sformatf("addr_ch%0d", w), 64'(sdram_addr), 64'(mabs));
    mwin = w;
    mrel = adr(w);
    mlast = w;
    mdisc = 0;
  endtask

  task automatic do_ack(input int d);
    repeat (d) begin
      @(negedge clk);
      chk("req_hold", 64'(sdram_req), 64'd1);
      chk("addr_hold", 64'(sdram_addr), 64'(mabs));
    end
    sdram_ack = 1;
    @(negedge clk);
    sdram_ack = 0;
    chk("req_drop", 64'(sdram_req), 64'd0);
  endtask

  task automatic do_rdy(input int d, input logic [15:0] data);
    repeat (d) @(negedge clk);
    data_read = data;
    sdram_rdy = 1;
    @(negedge clk);
    sdram_rdy = 0;
    if (!mdisc && !downloading) begin
      mval[mwin] = 1;
      mtag[mwin] = mrel;
      mdata[mwin] = data;
    end
  endtask

  task automatic check_ok();
    #1;
    for (int n = 0; n < CH; n++) begin
      chk($sformatf("ok%0d", n), 64'(ch_ok[n]), 64'(mok(n)));
      if (mok(n)) chk($sformatf("dout%0d", n), 64'(ch_dout[n*16 +: 16]), 64'(mdata[n]));
    end
  endtask

  task automatic serve(input int w);
    wait_req(w);
    do_ack($urandom_range(0, 3));
    do_rdy($urandom_range(0, 4), 16'($urandom));
    check_ok();
  endtask

  task automatic idle_check(input int cycles, input string tag);
    repeat (cycles) begin
      @(negedge clk);
      #1;
      chk({tag, "_noreq"}, 64'(sdram_req), 64'd0);
      chk({tag, "_arf"}, 64'(autorefresh), 64'd1);
    end
  endtask

  initial begin
    int w;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 64'(sdram_req), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_arf", 64'(autorefresh), 64'd1);
    chk("rst_ok", 64'(ch_ok), 64'd0);
    chk("rst_dout", 64'(ch_dout), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ch_addr[0 +: AW] = 22'h100;
    ch_cs = 4'b0001;
    wait_req(0);
    chk("single_addr", 64'(sdram_addr), 64'h0C100);
    do_ack(1);
    do_rdy(3, 16'hBEEF);
    check_ok();
    chk("single_ok", 64'(ch_ok[0]), 64'd1);
    chk("single_dout", 64'(ch_dout[15:0]), 64'hBEEF);
    do_reset();
    ch_addr = {22'h000200, 22'h000007, 22'h000020, 22'h000300};
    ch_cs = 4'b1111;
    for (int i = 0; i < CH; i++) serve(i);
    chk("all_hit", 64'(ch_ok), 64'hF);
    idle_check(3, "hit_idle");
    ch_cs[1] = 0;
    @(negedge clk);
    ch_cs[1] = 1;
    #1;
    chk("rehit_ok1", 64'(ch_ok[1]), 64'd1);
    idle_check(3, "rehit");
    ch_addr[2*AW +: AW] = 22'h40;
    wait_req(2);
    do_ack(0);
    ch_addr[2*AW +: AW] = 22'h41;
    do_rdy(1, 16'h1234);
    check_ok();
    chk("chg_ok2_low", 64'(ch_ok[2]), 64'd0);
    wait_req(2);
    chk("chg_addr41", 64'(sdram_addr), 64'(22'h41 + 22'h200000));
    do_ack(0);
    do_rdy(0, 16'h4141);
    check_ok();
    chk("chg_ok2_high", 64'(ch_ok[2]), 64'd1);
    ch_addr[3*AW +: AW] = 22'h201;
    wait_req(3);
    chk("wrap_addr", 64'(sdram_addr), 64'h000101);
    do_ack(0);
    downloading = 1;
    for (int n = 0; n < CH; n++) mval[n] = 0;
    mdisc = 1;
    do_rdy(2, 16'hDEAD);
    check_ok();
    chk("dl_ok_clear", 64'(ch_ok), 64'd0);
    idle_check(4, "dl");
    downloading = 0;
    w = mpick();
    chk("dl_resume_pick", 64'(w), 64'd0);
    while (w >= 0) begin
      serve(w);
      w = mpick();
    end
    @(negedge clk);
    ch_addr[0 +: AW] = 22'h55;
    wait_req(0);
    rst_n = 0;
    #1;
    chk("arst_req", 64'(sdram_req), 64'd0);
    chk("arst_addr", 64'(sdram_addr), 64'd0);
    chk("arst_ok", 64'(ch_ok), 64'd0);
    chk("arst_arf", 64'(autorefresh), 64'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int it = 0; it < 80; it++) begin
      w = mpick();
      if (w < 0) begin
        check_ok();
        chk("rnd_noreq", 64'(sdram_req), 64'd0);
        chk("rnd_arf", 64'(autorefresh), 64'd1);
        @(negedge clk);
        ch_cs = 4'($urandom);
        for (int n = 0; n < CH; n++) ch_addr[n*AW +: AW] = pool[$urandom_range(0, 3)];
      end else serve(w);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
